// File: rtl/output_stream_gen.sv
// Paced valid/ready beat generator: emits cfg_count beats with cfg_period
// idle cycles before each one, and reports busy/done status.
module output_stream_gen #(
  parameter int IDX_W    = 32,
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                start,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [IDX_W-1:0]    cfg_count,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [IDX_W-1:0]    m_idx,
  output logic                m_last,
  output logic                busy,
  output logic                done
);

  // state  | meaning
  // IDLE   | no run since reset
  // GAP    | counting idle cycles before the next beat
  // VALID  | beat offered, waiting for m_ready
  // DONE   | run complete, outputs held until next start
  typedef enum logic [1:0] {S_IDLE, S_GAP, S_VALID, S_DONE} state_t;

  state_t              state;
  logic [PERIOD_W-1:0] period_r;
  logic [PERIOD_W-1:0] gap_cnt;
  logic [IDX_W-1:0]    count_r;

  logic [PERIOD_W:0]   gap_inc;
  logic                gap_hit;
  logic [IDX_W-1:0]    idx_next;
  logic [IDX_W-1:0]    last_idx;
  logic                on_last;

  // Gap ends on the edge where the counter would reach period_r, so the
  // beat appears exactly period_r cycles after the gap opened.
  assign gap_inc  = {1'b0, gap_cnt} + (PERIOD_W+1)'(1);
  assign gap_hit  = (gap_inc == {1'b0, period_r});
  assign idx_next = m_idx + IDX_W'(1);
  assign last_idx = count_r - IDX_W'(1);
  assign on_last  = (m_idx == last_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      period_r <= '0;
      gap_cnt  <= '0;
      count_r  <= '0;
      m_valid  <= 1'b0;
      m_idx    <= '0;
      m_last   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            period_r <= cfg_period;
            count_r  <= cfg_count;
            m_idx    <= '0;
            gap_cnt  <= '0;
            if (cfg_count == '0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              busy <= 1'b1;
              done <= 1'b0;
              // A zero gap offers the first beat right away.
              if (cfg_period == '0) begin
                state   <= S_VALID;
                m_valid <= 1'b1;
                m_last  <= (cfg_count == IDX_W'(1));
              end else begin
                state <= S_GAP;
              end
            end
          end
        end

        S_GAP: begin
          if (en) begin
            if (gap_hit) begin
              state   <= S_VALID;
              m_valid <= 1'b1;
              m_last  <= on_last;
            end else begin
              gap_cnt <= gap_inc[PERIOD_W-1:0];
            end
          end
        end

        S_VALID: begin
          if (m_ready) begin
            if (on_last) begin
              state   <= S_DONE;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              m_idx   <= idx_next;
              gap_cnt <= '0;
              if (period_r == '0) begin
                m_last <= (idx_next == last_idx);
              end else begin
                state   <= S_GAP;
                m_valid <= 1'b0;
                m_last  <= 1'b0;
              end
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_stream_gen.sv
// Scoreboard bench for output_stream_gen: stimulus pushes hand-computed beats
// (index, last flag, cycle) and a monitor pops them on every handshake.
module tb_output_stream_gen;

  localparam int IDX_W    = 32;
  localparam int PERIOD_W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic                start;
  logic [PERIOD_W-1:0] cfg_period;
  logic [IDX_W-1:0]    cfg_count;
  logic                m_valid;
  logic                m_ready;
  logic [IDX_W-1:0]    m_idx;
  logic                m_last;
  logic                busy;
  logic                done;

  output_stream_gen #(.IDX_W(IDX_W), .PERIOD_W(PERIOD_W)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .cfg_period(cfg_period), .cfg_count(cfg_count),
    .m_valid(m_valid), .m_ready(m_ready), .m_idx(m_idx), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int idx;
    bit last;
    int cyc;
  } beat_t;

  beat_t sb[$];
  beat_t mon_e;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int idx, input bit last, input int c);
    beat_t b;
    b.idx  = idx;
    b.last = last;
    b.cyc  = c;
    sb.push_back(b);
  endtask

  // Returns at the falling edge inside cycle n.
  task automatic goto_cyc(input int n);
    int g;
    g = 0;
    while (cyc < n && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != n) begin
      checks++;
      errors++;
      $display("FAIL goto_cyc: got %0d expected %0d", cyc, n);
    end
  endtask

  task automatic do_start(input int per, input int cnt, output int t);
    @(negedge clk);
    cfg_period = PERIOD_W'(per);
    cfg_count  = IDX_W'(cnt);
    start      = 1'b1;
    t          = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_status(input string name, input bit b, input bit d);
    chk({name, "_busy"}, busy, b);
    chk({name, "_done"}, done, d);
    chk({name, "_valid"}, m_valid, 0);
  endtask

  // Monitor samples after the stimulus has settled inputs for this cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && m_valid && m_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got idx %0d expected no beat (cycle %0d)", m_idx, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("beat_idx", m_idx, mon_e.idx);
          chk("beat_last", m_last, mon_e.last);
          chk("beat_cyc", cyc, mon_e.cyc);
        end
      end
      if (m_valid && done) begin
        checks++;
        errors++;
        $display("FAIL valid_with_done: got valid=1 done=1 expected not both (cycle %0d)", cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst        = 1'b1;
    en         = 1'b1;
    start      = 1'b0;
    m_ready    = 1'b1;
    cfg_period = '0;
    cfg_count  = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", m_valid, 0);
    chk("rst_idx", m_idx, 0);
    chk("rst_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    // Pacing: period 5, count 4
    do_start(5, 4, t);
    push(0, 0, t + 6); push(1, 0, t + 12); push(2, 0, t + 18); push(3, 1, t + 24);
    chk("pace_busy_t1", busy, 1);
    goto_cyc(t + 24);
    chk("pace_busy_t24", busy, 1);
    goto_cyc(t + 25);
    chk_status("pace_end", 0, 1);

    // Backpressure: period 2, count 3, ready low for 4 cycles on beat 1
    do_start(2, 3, t);
    push(0, 0, t + 3); push(1, 0, t + 10); push(2, 1, t + 13);
    goto_cyc(t + 5);
    m_ready = 1'b0;
    for (int k = 6; k <= 9; k++) begin
      goto_cyc(t + k);
      chk("bp_valid_hold", m_valid, 1);
      chk("bp_idx_hold", m_idx, 1);
    end
    goto_cyc(t + 10);
    m_ready = 1'b1;
    goto_cyc(t + 14);
    chk_status("bp_end", 0, 1);

    // Gating: period 4, count 1, en low for 3 gap cycles
    do_start(4, 1, t);
    push(0, 1, t + 8);
    goto_cyc(t + 2);
    en = 1'b0;
    goto_cyc(t + 5);
    en = 1'b1;
    goto_cyc(t + 9);
    chk_status("gate_end", 0, 1);

    // Zero gap: period 0, count 5
    do_start(0, 5, t);
    for (int k = 0; k < 5; k++) push(k, (k == 4), t + 1 + k);
    goto_cyc(t + 6);
    chk_status("zero_end", 0, 1);

    // Zero count
    do_start(3, 0, t);
    chk_status("cnt0", 0, 1);
    goto_cyc(t + 6);
    chk_status("cnt0_hold", 0, 1);

    // Restart from DONE with new cfg
    do_start(1, 2, t);
    push(0, 0, t + 2); push(1, 1, t + 4);
    chk("restart_done_clr", done, 0);
    chk("restart_busy", busy, 1);
    goto_cyc(t + 5);
    chk_status("restart_end", 0, 1);

    // Start while busy is ignored
    do_start(3, 2, t);
    push(0, 0, t + 4); push(1, 1, t + 8);
    goto_cyc(t + 2);
    cfg_period = '0;
    cfg_count  = IDX_W'(7);
    start      = 1'b1;
    goto_cyc(t + 3);
    start = 1'b0;
    goto_cyc(t + 9);
    chk_status("busy_start_end", 0, 1);

    // Reset while a beat is offered
    m_ready = 1'b0;
    do_start(2, 3, t);
    goto_cyc(t + 3);
    chk("rstmid_valid", m_valid, 1);
    rst = 1'b1;
    goto_cyc(t + 4);
    chk("rstmid_valid0", m_valid, 0);
    chk("rstmid_idx0", m_idx, 0);
    chk("rstmid_last0", m_last, 0);
    chk("rstmid_busy0", busy, 0);
    chk("rstmid_done0", done, 0);
    rst     = 1'b0;
    m_ready = 1'b1;
    do_start(1, 1, t);
    push(0, 1, t + 2);
    goto_cyc(t + 3);
    chk_status("post_rst_end", 0, 1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_stream_gen.md
# output_stream_gen

Parametrised successor to the fixed-rate output-valid pulser. It emits a programmable number of beats on an AXI-Stream-style valid/ready master port, with a programmable idle gap between beats. It adds backpressure, a beat index, last-beat flagging, start/restart and completion status. It sits between the core's result path and the AXI output DMA/UART framer, pacing how often output words are offered downstream.

## Interface
Parameters:
- IDX_W, 32, width of beat count and index
- PERIOD_W, 8, width of gap configuration
- Constraint: cfg_count ≤ 2^IDX_W − 1

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  gap-counter enable; low freezes gap counting only
- start  in  1  one-cycle request; latches cfg_* and begins a run
- cfg_period  in  PERIOD_W  idle cycles inserted before each beat
- cfg_count  in  IDX_W  total beats in the run
- m_valid  out  1  beat offered
- m_ready  in  1  downstream accepts beat
- m_idx  out  IDX_W  zero-based index of the current beat
- m_last  out  1  high with m_valid on the final beat
- busy  out  1  run in progress
- done  out  1  run complete; level, held until next start or rst

## Operation
- States: IDLE, GAP, VALID, DONE. Reset enters IDLE.
- IDLE, start=1:
  - latch period_r←cfg_period, count_r←cfg_count, m_idx←0, gap counter←0, busy←1
  - go to GAP; if cfg_count=0, go directly to DONE with busy=0 and done=1
- GAP:
  - gap counter increments on each cycle with en=1
  - when counter reaches period_r (checked with en=1, or immediately if period_r=0), go to VALID with m_valid=1
  - en=0 holds both the counter and the state
- VALID:
  - m_valid stays high and m_idx/m_last stay stable until m_ready=1; en has no effect here
  - on handshake (m_valid & m_ready):
    - if m_idx = count_r−1: go to DONE, m_valid←0, m_last←0, busy←0, done←1
    - else: m_idx←m_idx+1, counter←0; go to GAP, or stay in VALID if period_r=0 (back-to-back beats)
- m_last = VALID & (m_idx = count_r−1), registered.
- DONE: outputs hold; start=1 behaves as start in IDLE (done←0 on the same edge).
- start while busy is ignored; cfg_* changes mid-run have no effect.
- Counters are IDX_W/PERIOD_W unsigned. Comparison is equality, so the gap counter never wraps.
- rst mid-run: all state returns to IDLE on the next edge and any in-flight beat is dropped.

## Timing
- Reset values: m_valid=0, m_idx=0, m_last=0, busy=0, done=0.
- start sampled at edge t with en held high: busy=1 from t+1, first m_valid from t+1+cfg_period.
- Handshake at edge h with m_ready and en high: next m_valid at h+1+period_r. The beat period is period_r+1 cycles.
- Each en=0 cycle in GAP delays the next beat by exactly one cycle.
- Final handshake at edge h: done=1 and busy=0 from h+1. m_valid is never high while done=1.
- All outputs are registered; no combinational path from m_ready to m_valid.

## Test plan
- Pacing: rst, then start with cfg_period=5, cfg_count=4, m_ready=1, en=1 → m_valid pulses at t+6, t+12, t+18, t+24. m_idx is 0..3, m_last only on idx 3, done=1 at t+25.
- Backpressure: period=2, count=3, m_ready low for 4 cycles during beat 1 → m_valid and m_idx=1 stay stable throughout. Beat 2 arrives 3 cycles after the delayed handshake; no beat is lost or duplicated.
- Gating and zero gap: en=0 for 3 cycles in GAP (period=4) → beat delayed by exactly 3 cycles. period=0, count=5, m_ready=1 → 5 consecutive valid cycles, done on the 6th.
- Edge counts:
  - count=0 → done=1 at t+1 with no m_valid.
  - count=1 → single beat with m_last=1.
  - start while busy → ignored.
  - start in DONE → new run with the newly latched cfg.
- Reset mid-run: rst asserted while m_valid=1 → next cycle all outputs at reset values, state IDLE; a following start behaves normally.
